// File: rtl/dispatch_pkg.sv
// Shared types and default sizing for the matmul core dispatcher.
package dispatch_pkg;

  localparam int DEFAULT_NUM_CORES = 4;
  localparam int DEFAULT_CNT_W     = 16;
  localparam int DEFAULT_TIMEOUT   = 1024;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/core_dispatcher_if.sv
// Host/core bundle of the dispatcher: launch request, per-core clear/start levels and run report.
interface core_dispatcher_if
  import dispatch_pkg::*;
#(
  parameter int NUM_CORES = DEFAULT_NUM_CORES,
  parameter int CNT_W     = DEFAULT_CNT_W
);

  logic                 start;
  logic [NUM_CORES-1:0] core_mask;
  logic [NUM_CORES-1:0] end_process;
  logic [NUM_CORES-1:0] core_rst;
  logic [NUM_CORES-1:0] status;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     cycles;
  logic                 timeout;
  logic [NUM_CORES-1:0] stuck_mask;

  modport master (
    output start, core_mask, end_process,
    input  core_rst, status, busy, done, cycles, timeout, stuck_mask
  );

  modport slave (
    input  start, core_mask, end_process,
    output core_rst, status, busy, done, cycles, timeout, stuck_mask
  );

endinterface

// File: rtl/end_detect.sv
// Per-core completion tracker: rising-edge detect on end_process plus a sticky completion flag.
module end_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic level,
  output logic rise,
  output logic flag
);

  logic prev;

  assign rise = level & ~prev;

  // prev always tracks the level, so a level already high when RUN begins never looks like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
      flag <= 1'b0;
    end else begin
      prev <= level;
      if (clear)
        flag <= 1'b0;
      else if (enable && rise)
        flag <= 1'b1;
    end
  end

endmodule

// File: rtl/core_dispatcher.sv
// Clears, launches and collects completions from the matmul cores; reports run length.
// Defining DISPATCH_TIMEOUT_EN adds a TIMEOUT RUN-cycle limit with timeout/stuck_mask reporting.
module core_dispatcher
  import dispatch_pkg::*;
#(
  parameter int NUM_CORES = DEFAULT_NUM_CORES,
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input logic              clk,
  input logic              rst_n,
  core_dispatcher_if.slave bus
);

  state_t               state;
  state_t               state_next;
  logic [NUM_CORES-1:0] mask;
  logic [NUM_CORES-1:0] rise;
  logic [NUM_CORES-1:0] flags;
  logic [NUM_CORES-1:0] core_rst;
  logic [NUM_CORES-1:0] status;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     cycles;
  logic [CNT_W-1:0]     cycles_inc;
  logic                 accept;
  logic                 in_run;
  logic                 complete;
  logic                 limit_hit;

  assign accept     = (state == IDLE) && bus.start;
  assign in_run     = (state == RUN);
  assign complete   = ((flags | rise) & mask) == mask;
  assign cycles_inc = (cycles == '1) ? cycles : cycles + CNT_W'(1);

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    end_detect u_end_detect (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (accept),
      .enable (in_run),
      .level  (bus.end_process[i]),
      .rise   (rise[i]),
      .flag   (flags[i])
    );
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic                 timeout_q;
  logic [NUM_CORES-1:0] stuck_q;

  assign limit_hit = (cycles_inc == LIMIT);

  // Completion in the limit cycle takes priority, so the report only records a genuine timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
      stuck_q   <= '0;
    end else if (accept) begin
      timeout_q <= 1'b0;
      stuck_q   <= '0;
    end else if (in_run && !complete && limit_hit) begin
      timeout_q <= 1'b1;
      stuck_q   <= mask & ~(flags | rise);
    end
  end

  assign bus.timeout    = timeout_q;
  assign bus.stuck_mask = stuck_q;
`else
  logic unused_limit;

  assign unused_limit   = ^TIMEOUT;
  assign limit_hit      = 1'b0;
  assign bus.timeout    = 1'b0;
  assign bus.stuck_mask = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CLEAR;
      CLEAR:   state_next = RUN;
      RUN:     if (complete || limit_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask     <= '0;
      core_rst <= '0;
      status   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cycles   <= '0;
    end else begin
      core_rst <= accept ? bus.core_mask : '0;
      status   <= (state_next == RUN) ? mask : '0;
      busy     <= (state_next == CLEAR) || (state_next == RUN);
      done     <= (state_next == DONE);
      if (accept) begin
        mask   <= bus.core_mask;
        cycles <= '0;
      end else if (in_run) begin
        cycles <= cycles_inc;
      end
    end
  end

  assign bus.core_rst = core_rst;
  assign bus.status   = status;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.cycles   = cycles;

endmodule
